// File: rtl/jtframe_cendivn_if.sv
// Bundle of the clock-enable divider signals: the input enable, per-channel
// divisors and phase sync in one direction, the divided enables in the other.
interface jtframe_cendivn_if #(
  parameter int W  = 4,
  parameter int CH = 2
);
  logic            cen_in;
  logic [CH*W-1:0] div;
  logic            sync;
  logic [CH-1:0]   cen_da;
  logic [CH-1:0]   cen_div;
  logic [CH-1:0]   tgl;

  modport master (output cen_in, div, sync, input  cen_da, cen_div, tgl);
  modport slave  (input  cen_in, div, sync, output cen_da, cen_div, tgl);
endinterface

// File: rtl/jtframe_cendivn.sv
// Multi-channel clock-enable divider: each channel passes one cen_in in N.
// Define JTFRAME_CENDIVN_TGL_EN to build the per-channel 50% toggle outputs.
module jtframe_cendivn #(
  parameter int W  = 4,
  parameter int CH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  jtframe_cendivn_if.slave   bus
);

  logic [W-1:0]  cnt    [CH];
  logic [W-1:0]  nlat   [CH];
  logic [W-1:0]  div_ch [CH];
  logic [CH-1:0] da;
  logic [CH-1:0] cen_div_q;

  always_comb begin
    da = '0;
    for (int i = 0; i < CH; i++) begin
      div_ch[i] = bus.div[i*W +: W];
      da[i]     = bus.cen_in & ((cnt[i] == '0) | bus.sync);
    end
  end

  // The divisor is only sampled on an output pulse, so a change mid-period
  // never produces a runt or stretched period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: cnt/nlat are a handful of flops, not a RAM, so clearing the
      // whole array on reset is cheap and keeps the first cen_in a pulse.
      for (int i = 0; i < CH; i++) begin
        cnt[i]  <= '0;
        nlat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (da[i]) begin
          // NOTE: non-blocking so every channel sees the pre-edge state.
          nlat[i] <= div_ch[i];
          cnt[i]  <= (div_ch[i] <= W'(1)) ? '0 : W'(1);
        end else if (bus.cen_in) begin
          if (nlat[i] <= W'(1) || cnt[i] == nlat[i] - W'(1)) cnt[i] <= '0;
          else                                               cnt[i] <= cnt[i] + W'(1);
        end else if (bus.sync) begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cen_div_q <= '0;
    else        cen_div_q <= da;
  end

  assign bus.cen_da  = da;
  assign bus.cen_div = cen_div_q;

`ifdef JTFRAME_CENDIVN_TGL_EN
  logic [CH-1:0] tgl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tgl_q <= '0;
    else        tgl_q <= tgl_q ^ da;
  end

  assign bus.tgl = tgl_q;
`else
  assign bus.tgl = '0;
`endif

endmodule

// File: tb/tb_jtframe_cendivn.sv
// Bench for jtframe_cendivn: countdown model checked every cycle plus
// directed scenarios with hand-computed pulse positions.
module tb_jtframe_cendivn;
  localparam int W  = 4;
  localparam int CH = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  jtframe_cendivn_if #(.W(W), .CH(CH)) bus ();

  jtframe_cendivn #(.W(W), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: rem[c] = cen_in pulses still to skip before the next output pulse.
  int            rem [CH];
  logic [CH-1:0] m_da, m_div, m_tgl;

  always @(negedge clk) begin
    int d;
    if (!rst_n) begin
      foreach (rem[c]) rem[c] = 0;
      m_div = '0;
      m_tgl = '0;
      check("model_rst_da",  32'(bus.cen_da),  32'({CH{bus.cen_in}}));
      check("model_rst_div", 32'(bus.cen_div), 32'(0));
      check("model_rst_tgl", 32'(bus.tgl),     32'(0));
    end else begin
      for (int c = 0; c < CH; c++) m_da[c] = bus.cen_in && (rem[c] == 0 || bus.sync);
      check("model_da",  32'(bus.cen_da),  32'(m_da));
      check("model_div", 32'(bus.cen_div), 32'(m_div));
`ifdef JTFRAME_CENDIVN_TGL_EN
      check("model_tgl", 32'(bus.tgl), 32'(m_tgl));
`else
      check("model_tgl", 32'(bus.tgl), 32'(0));
`endif
      for (int c = 0; c < CH; c++) begin
        d = int'(bus.div[c*W +: W]);
        if (m_da[c]) begin
          rem[c]   = (d <= 1) ? 0 : d - 1;
          m_tgl[c] = ~m_tgl[c];
        end else if (bus.cen_in) begin
          rem[c]--;
        end else if (bus.sync) begin
          rem[c] = 0;
        end
      end
      m_div = m_da;
    end
  end

  // Inputs change just after the rising edge; the caller samples at the falling edge.
  task automatic drive(input logic ci, input logic sy, input int d0, input int d1);
    @(posedge clk);
    #1;
    bus.cen_in = ci;
    bus.sync   = sy;
    bus.div    = {W'(d1), W'(d0)};
    @(negedge clk);
  endtask

  logic t0;
  logic e0, e1;

  initial begin
    rst_n      = 1'b0;
    bus.cen_in = 1'b0;
    bus.sync   = 1'b0;
    bus.div    = '0;
    repeat (3) @(negedge clk);
    check("reset_da",  32'(bus.cen_da),  32'(0));
    check("reset_div", 32'(bus.cen_div), 32'(0));
    check("reset_tgl", 32'(bus.tgl),     32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // cen_in held high, ch0 /3, ch1 pass-through
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b0, 3, 0);
      check($sformatf("t1_da k=%0d", k), 32'(bus.cen_da), 32'({1'b1, (k % 3 == 0)}));
      check($sformatf("t1_div k=%0d", k), 32'(bus.cen_div),
            32'({(k > 0), (k > 0 && (k - 1) % 3 == 0)}));
    end

    // cen_in every 4th clock, ch0 /2: pulses at clk 0, 8, 16
    for (int k = 0; k < 24; k++) begin
      drive(k % 4 == 0, k == 0, 2, 0);
      if (k == 0) t0 = bus.tgl[0];
      check($sformatf("t2_da k=%0d", k),  32'(bus.cen_da[0]),  32'(k % 8 == 0));
      check($sformatf("t2_div k=%0d", k), 32'(bus.cen_div[0]), 32'(k % 8 == 1));
`ifdef JTFRAME_CENDIVN_TGL_EN
      check($sformatf("t2_tgl k=%0d", k), 32'(bus.tgl[0]), 32'(t0 ^ (((k + 7) / 8) % 2 == 1)));
`else
      check($sformatf("t2_tgl k=%0d", k), 32'(bus.tgl[0]), 32'(0));
`endif
    end

    // ch0 /4, switched to /2 after the 2nd cen_in of the period: pulses 0,4,6,8,10
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, k == 0, (k < 2) ? 4 : 2, 0);
      check($sformatf("t3_da k=%0d", k), 32'(bus.cen_da[0]),
            32'(k == 0 || k == 4 || k == 6 || k == 8 || k == 10));
    end

    // ch0 /5, ch1 /3; 7 cen_in, then sync alone, then restart at k=8
    for (int k = 0; k < 20; k++) begin
      if (k < 7) begin
        drive(1'b1, k == 0, 5, 3);
        e0 = (k % 5 == 0);
        e1 = (k % 3 == 0);
      end else if (k == 7) begin
        drive(1'b0, 1'b1, 5, 3);
        e0 = 1'b0;
        e1 = 1'b0;
      end else begin
        drive(1'b1, 1'b0, 5, 3);
        e0 = ((k - 8) % 5 == 0);
        e1 = ((k - 8) % 3 == 0);
      end
      check($sformatf("t4_da k=%0d", k), 32'(bus.cen_da), 32'({e1, e0}));
    end

    // sync together with cen_in at cnt=2 (div 4): pulses 0,2,6,10
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, k == 0 || k == 2, 4, 0);
      check($sformatf("t5_da k=%0d", k), 32'(bus.cen_da[0]),
            32'(k == 0 || k == 2 || k == 6 || k == 10));
    end

    // async reset mid-period with ch0 at cnt=3
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 4, 0);
    check("t6_pre_da",  32'(bus.cen_da),  32'(2'b10));
    check("t6_pre_div", 32'(bus.cen_div), 32'(2'b10));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_div", 32'(bus.cen_div), 32'(0));
    check("t6_async_tgl", 32'(bus.tgl),     32'(0));
    check("t6_async_da",  32'(bus.cen_da),  32'(2'b11));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_first_da", 32'(bus.cen_da), 32'(2'b11));
    drive(1'b1, 1'b0, 4, 0);
    check("t6_second_da", 32'(bus.cen_da), 32'(2'b10));
    check("t6_second_div", 32'(bus.cen_div), 32'(2'b11));

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
